// File: rtl/acc_alu_seq.sv
// Accumulator ALU with a small operand register file and a slice-serial adder.
// One command in flight; LDA/STA/AND/XOR finish in one cycle, arithmetic runs LSB slice first.
module acc_alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 4,
    parameter int unsigned SLICE = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [$clog2(NREGS)-1:0] cmd_rs,
    input  logic [$clog2(NREGS)-1:0] cmd_rd,
    input  logic [WIDTH-1:0]         cmd_data,
    output logic                     rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     flag_c,
    output logic                     flag_z,
    output logic                     flag_n,
    output logic                     flag_v
);

    localparam int unsigned STEPS = WIDTH / SLICE;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("acc_alu_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];
    logic               c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   b_sel;
    logic [WIDTH-1:0]   logic_res;
    logic [SLICE:0]     slice_sum;
    logic [WIDTH-1:0]   res_next;
    logic               slice_ovf;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        acc_d       = acc_q;
        regs_d      = regs_q;
        c_d         = c_q;
        z_d         = z_q;
        n_d         = n_q;
        v_d         = v_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_d       = res_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;

        b_sel     = regs_q[cmd_rs];
        logic_res = (cmd_op == OP_AND) ? (acc_q & b_sel) : (acc_q ^ b_sel);
        slice_sum = {1'b0, a_sh_q[SLICE-1:0]} + {1'b0, b_sh_q[SLICE-1:0]}
                  + (SLICE+1)'(carry_q);
        // Completed slices shift in from the top, so after STEPS slices res is LSB-aligned
        res_next  = (res_q >> SLICE) | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
        slice_ovf = (a_sh_q[SLICE-1] == b_sh_q[SLICE-1]) &&
                    (slice_sum[SLICE-1] != a_sh_q[SLICE-1]);

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d = DONE;
                    unique case (cmd_op)
                        OP_LDA: begin
                            acc_d = cmd_data;
                            z_d   = (cmd_data == '0);
                            n_d   = cmd_data[WIDTH-1];
                        end
                        OP_STA: regs_d[cmd_rd] = acc_q;
                        OP_AND, OP_XOR: begin
                            acc_d = logic_res;
                            z_d   = (logic_res == '0);
                            n_d   = logic_res[WIDTH-1];
                            v_d   = 1'b0;
                        end
                        default: begin
                            // Subtract forms add the inverted operand; cin selects by opcode
                            state_d = EXEC;
                            a_sh_d  = acc_q;
                            b_sh_d  = cmd_op[0] ? ~b_sel : b_sel;
                            res_d   = '0;
                            cnt_d   = '0;
                            if (cmd_op == OP_ADD)      carry_d = 1'b0;
                            else if (cmd_op == OP_SUB) carry_d = 1'b1;
                            else                       carry_d = c_q;
                        end
                    endcase
                end
            end
            EXEC: begin
                a_sh_d  = a_sh_q >> SLICE;
                b_sh_d  = b_sh_q >> SLICE;
                res_d   = res_next;
                carry_d = slice_sum[SLICE];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = DONE;
                    acc_d   = res_next;
                    c_d     = slice_sum[SLICE];
                    v_d     = slice_ovf;
                    z_d     = (res_next == '0);
                    n_d     = res_next[WIDTH-1];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            acc_q       <= '0;
            regs_q      <= '{default: '0};
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            acc_q       <= acc_d;
            regs_q      <= regs_d;
            c_q         <= c_d;
            z_q         <= z_d;
            n_q         <= n_d;
            v_q         <= v_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = acc_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_v    = v_q;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Randomized bench for acc_alu_seq against an arithmetic reference model of ACC, registers and flags.
module tb_acc_alu_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREGS = 4;
    localparam int unsigned SLICE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rs;
    logic [1:0] cmd_rd;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       flag_c, flag_z, flag_n, flag_v;

    always #5 clk = ~clk;

    acc_alu_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rs    (cmd_rs),
        .cmd_rd    (cmd_rd),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v)
    );

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [7:0] m_acc;
    logic [7:0] m_r [4];
    logic       m_c, m_z, m_n, m_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = '0;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        {m_c, m_z, m_n, m_v} = 4'b0000;
    endtask

    // Apply one command to the model; returns expected accept-to-response latency
    task automatic model_exec(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rd,
                              input logic [7:0] d, output int lat);
        logic [7:0] b, bx;
        int cin, u, s;
        b = m_r[rs];
        lat = 1;
        case (op)
            3'd0: begin m_acc = d; m_z = (d == 0); m_n = d[7]; end
            3'd1: m_r[rd] = m_acc;
            3'd6, 3'd7: begin
                m_acc = (op == 3'd6) ? (m_acc & b) : (m_acc ^ b);
                m_z = (m_acc == 0); m_n = m_acc[7]; m_v = 1'b0;
            end
            default: begin
                bx  = op[0] ? ~b : b;
                cin = (op == 3'd2) ? 0 : (op == 3'd3) ? 1 : int'(m_c);
                u   = int'(m_acc) + int'(bx) + cin;
                s   = int'($signed(m_acc)) + int'($signed(bx)) + cin;
                m_c = (u > 255);
                m_v = (s > 127) || (s < -128);
                m_acc = 8'(u);
                m_z = (m_acc == 0); m_n = m_acc[7];
                lat = 1 + int'(WIDTH / SLICE) + 0 + 0 + 0 + 1 - 1;
            end
        endcase
    endtask

    // Issue one command at a negedge; optionally keep cmd_valid high with junk while busy
    task automatic do_cmd(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rd,
                          input logic [7:0] d, input bit noise);
        int n, lat, lat_exp;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            check("ready_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rd = rd; cmd_data = d;
        @(posedge clk);
        model_exec(op, rs, rd, d, lat_exp);
        @(negedge clk);
        cmd_valid = noise;
        cmd_op = 3'($urandom); cmd_rs = 2'($urandom); cmd_rd = 2'($urandom); cmd_data = 8'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            check("busy_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        cmd_valid = 1'b0;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("latency", 32'(lat), 32'(lat_exp));
        check("rsp_data", 32'(rsp_data), 32'(m_acc));
        check("flags_czn v", 32'({flag_c, flag_z, flag_n, flag_v}), 32'({m_c, m_z, m_n, m_v}));
        @(negedge clk);
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("ready_back", 32'(cmd_ready), 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic [3:0] czvn);
        check(tag, 32'({rsp_data, flag_c, flag_z, flag_n, flag_v}), 32'({d, czvn}));
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rs = '0; cmd_rd = '0; cmd_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        expect_out("rst_out", 8'h00, 4'b0000);
        rst_n = 1'b1;
        check("ready_after_rst0", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("ready_after_rst1", 32'(cmd_ready), 32'd1);

        // Directed sequences with absolute expected values ({C,Z,N,V})
        do_cmd(3'd0, 2'd0, 2'd0, 8'h05, 1'b1);
        do_cmd(3'd1, 2'd0, 2'd1, 8'h00, 1'b1);
        do_cmd(3'd0, 2'd0, 2'd0, 8'h03, 1'b1);
        do_cmd(3'd2, 2'd1, 2'd0, 8'h00, 1'b1);
        expect_out("add_5_3", 8'h08, 4'b0000);

        do_cmd(3'd0, 2'd0, 2'd0, 8'hFF, 1'b1);
        do_cmd(3'd1, 2'd0, 2'd2, 8'h00, 1'b1);
        do_cmd(3'd0, 2'd0, 2'd0, 8'h01, 1'b1);
        do_cmd(3'd2, 2'd2, 2'd0, 8'h00, 1'b1);
        expect_out("add_wrap", 8'h00, 4'b1100);

        do_cmd(3'd0, 2'd0, 2'd0, 8'h05, 1'b1);
        do_cmd(3'd1, 2'd0, 2'd0, 8'h00, 1'b1);
        do_cmd(3'd3, 2'd0, 2'd0, 8'h00, 1'b1);
        expect_out("sub_eq", 8'h00, 4'b1100);
        do_cmd(3'd0, 2'd0, 2'd0, 8'h03, 1'b1);
        do_cmd(3'd3, 2'd0, 2'd0, 8'h00, 1'b1);
        expect_out("sub_neg", 8'hFE, 4'b0010);

        do_cmd(3'd0, 2'd0, 2'd0, 8'h01, 1'b0);
        do_cmd(3'd1, 2'd0, 2'd3, 8'h00, 1'b0);
        do_cmd(3'd0, 2'd0, 2'd0, 8'h7F, 1'b0);
        do_cmd(3'd2, 2'd3, 2'd0, 8'h00, 1'b0);
        expect_out("add_ovf", 8'h80, 4'b0011);
        do_cmd(3'd0, 2'd0, 2'd0, 8'h00, 1'b0);
        expect_out("lda_keep_cv", 8'h00, 4'b0101);

        // 0x01FF + 0x0001 with r3=01, r1=00
        do_cmd(3'd1, 2'd0, 2'd1, 8'h00, 1'b1);
        do_cmd(3'd0, 2'd0, 2'd0, 8'hFF, 1'b1);
        do_cmd(3'd2, 2'd3, 2'd0, 8'h00, 1'b1);
        expect_out("mp_lo", 8'h00, 4'b1100);
        do_cmd(3'd0, 2'd0, 2'd0, 8'h01, 1'b1);
        do_cmd(3'd4, 2'd1, 2'd0, 8'h00, 1'b1);
        expect_out("mp_hi", 8'h02, 4'b0000);

        // Reset in the second EXEC cycle with cmd_valid held high
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_rs = 2'd3; cmd_rd = 2'd0; cmd_data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_valid", 32'(rsp_valid), 32'd0);
            check("rst_mid_ready", 32'(cmd_ready), 32'd0);
        end
        expect_out("rst_mid_out", 8'h00, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_valid2", 32'(rsp_valid), 32'd0);
        check("rst_mid_ready2", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;

        // AND/XOR leave carry alone
        do_cmd(3'd0, 2'd0, 2'd0, 8'hFF, 1'b1);
        do_cmd(3'd1, 2'd0, 2'd2, 8'h00, 1'b1);
        do_cmd(3'd0, 2'd0, 2'd0, 8'h01, 1'b1);
        do_cmd(3'd2, 2'd2, 2'd0, 8'h00, 1'b1);
        do_cmd(3'd0, 2'd0, 2'd0, 8'h0F, 1'b1);
        do_cmd(3'd6, 2'd2, 2'd0, 8'h00, 1'b1);
        expect_out("and_ff", 8'h0F, 4'b1000);
        do_cmd(3'd7, 2'd2, 2'd0, 8'h00, 1'b1);
        expect_out("xor_ff", 8'hF0, 4'b1010);

        // Random commands against the model
        for (int k = 0; k < 300; k++) begin
            do_cmd(3'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            do_cmd(3'd0, 2'd0, 2'd0, 8'h00, 1'b0);
            do_cmd(3'd7, 2'(i), 2'd0, 8'h00, 1'b0);
            check("reg_readback", 32'(rsp_data), 32'(m_r[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
